// File: rtl/qp_derive_seq.sv
// Sequential Qp'Y / Qp'Cb / Qp'Cr derivation with div6/mod6 split, start/done handshake.
// Optional 4:2:2 chroma mapping (chroma_fmt_i port) enabled by defining QP_CHROMA_422_EN.
module qp_derive_seq #(
  parameter int BIT_DEPTH = 8,
  parameter int QP_W      = 7
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic signed [QP_W-1:0] qp_pred_i,
  input  logic signed [7:0]      delta_qp_i,
  input  logic signed [4:0]      cb_offset_i,
  input  logic signed [4:0]      cr_offset_i,
`ifdef QP_CHROMA_422_EN
  input  logic                   chroma_fmt_i,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic [QP_W-1:0]        qp_y_o,
  output logic [QP_W-1:0]        qp_cb_o,
  output logic [QP_W-1:0]        qp_cr_o,
  output logic [3:0]             qp_y_div6_o,
  output logic [3:0]             qp_cb_div6_o,
  output logic [3:0]             qp_cr_div6_o,
  output logic [2:0]             qp_y_mod6_o,
  output logic [2:0]             qp_cb_mod6_o,
  output logic [2:0]             qp_cr_mod6_o
);
  localparam int OFF = 6 * (BIT_DEPTH - 8);
  localparam int IW  = QP_W + 4;
  typedef logic signed [IW-1:0] sw_t;
  localparam sw_t OFF_S = sw_t'(OFF);
  localparam sw_t WRAP  = sw_t'(52 + OFF);
  localparam sw_t BIAS  = sw_t'(52 + 2 * OFF);
  localparam logic [QP_W-1:0] SIX = QP_W'(6);

  typedef enum logic [2:0] {IDLE, LUMA, CB, CR, DIV, DONE} state_t;
  state_t state;

  logic signed [QP_W-1:0] pred_r;
  logic signed [7:0]      delta_r;
  logic signed [4:0]      cb_off_r, cr_off_r;
  logic                   fmt_r;
  logic [QP_W-1:0]        qp_y_r, qp_cb_r, qp_cr_r;
  logic [QP_W-1:0]        rem_y, rem_cb, rem_cr;
  logic [3:0]             quot_y, quot_cb, quot_cr;

  sw_t s0, s1, s2, qpy_s, off_x, qpi_raw, qpi, qpc;
  logic [QP_W-1:0] y_new, c_new;
  logic            all_small;

  // 4:2:0 chroma QP mapping; identity below 30, table over 30..43, minus 6 above.
  function automatic sw_t map420(input sw_t q);
    sw_t r;
    r = q;
    if (q > sw_t'(43)) r = q - sw_t'(6);
    else if (q >= sw_t'(30)) begin
      case (q)
        sw_t'(30): r = sw_t'(29);
        sw_t'(31): r = sw_t'(30);
        sw_t'(32): r = sw_t'(31);
        sw_t'(33): r = sw_t'(32);
        sw_t'(34): r = sw_t'(33);
        sw_t'(35): r = sw_t'(33);
        sw_t'(36): r = sw_t'(34);
        sw_t'(37): r = sw_t'(34);
        sw_t'(38): r = sw_t'(35);
        sw_t'(39): r = sw_t'(35);
        sw_t'(40): r = sw_t'(36);
        sw_t'(41): r = sw_t'(36);
        sw_t'(42): r = sw_t'(37);
        default:   r = sw_t'(37);
      endcase
    end
    return r;
  endfunction

  always_comb begin
    // Biased sum is always positive; at most two wraps bring it into 0..51+OFF.
    s0 = sw_t'(pred_r) + sw_t'(delta_r) + BIAS;
    s1 = (s0 >= WRAP) ? s0 - WRAP : s0;
    s2 = (s1 >= WRAP) ? s1 - WRAP : s1;
    y_new = QP_W'(s2);

    // One shared chroma path, offset selected by which channel is being derived.
    qpy_s   = sw_t'(qp_y_r) - OFF_S;
    off_x   = (state == CB) ? sw_t'(cb_off_r) : sw_t'(cr_off_r);
    qpi_raw = qpy_s + off_x;
    if (qpi_raw < -OFF_S)          qpi = -OFF_S;
    else if (qpi_raw > sw_t'(57))  qpi = sw_t'(57);
    else                           qpi = qpi_raw;
`ifdef QP_CHROMA_422_EN
    if (fmt_r) qpc = (qpi > sw_t'(51)) ? sw_t'(51) : qpi;
    else       qpc = map420(qpi);
`else
    qpc = map420(qpi);
`endif
    c_new = QP_W'(qpc + OFF_S);

    all_small = (rem_y < SIX) && (rem_cb < SIX) && (rem_cr < SIX);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      pred_r       <= '0;
      delta_r      <= '0;
      cb_off_r     <= '0;
      cr_off_r     <= '0;
      fmt_r        <= 1'b0;
      qp_y_r       <= '0;
      qp_cb_r      <= '0;
      qp_cr_r      <= '0;
      rem_y        <= '0;
      rem_cb       <= '0;
      rem_cr       <= '0;
      quot_y       <= '0;
      quot_cb      <= '0;
      quot_cr      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      qp_y_o       <= '0;
      qp_cb_o      <= '0;
      qp_cr_o      <= '0;
      qp_y_div6_o  <= '0;
      qp_cb_div6_o <= '0;
      qp_cr_div6_o <= '0;
      qp_y_mod6_o  <= '0;
      qp_cb_mod6_o <= '0;
      qp_cr_mod6_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          pred_r   <= qp_pred_i;
          delta_r  <= delta_qp_i;
          cb_off_r <= cb_offset_i;
          cr_off_r <= cr_offset_i;
`ifdef QP_CHROMA_422_EN
          fmt_r    <= chroma_fmt_i;
`else
          fmt_r    <= 1'b0;
`endif
          busy_o   <= 1'b1;
          state    <= LUMA;
        end
        LUMA: begin
          qp_y_r <= y_new;
          rem_y  <= y_new;
          quot_y <= '0;
          state  <= CB;
        end
        CB: begin
          qp_cb_r <= c_new;
          rem_cb  <= c_new;
          quot_cb <= '0;
          state   <= CR;
        end
        CR: begin
          qp_cr_r <= c_new;
          rem_cr  <= c_new;
          quot_cr <= '0;
          state   <= DIV;
        end
        DIV: begin
          if (all_small) begin
            // Results land on the outputs exactly as DONE is entered.
            qp_y_o       <= qp_y_r;
            qp_cb_o      <= qp_cb_r;
            qp_cr_o      <= qp_cr_r;
            qp_y_div6_o  <= quot_y;
            qp_cb_div6_o <= quot_cb;
            qp_cr_div6_o <= quot_cr;
            qp_y_mod6_o  <= 3'(rem_y);
            qp_cb_mod6_o <= 3'(rem_cb);
            qp_cr_mod6_o <= 3'(rem_cr);
            done_o       <= 1'b1;
            state        <= DONE;
          end else begin
            if (rem_y >= SIX)  begin rem_y  <= rem_y  - SIX; quot_y  <= quot_y  + 4'd1; end
            if (rem_cb >= SIX) begin rem_cb <= rem_cb - SIX; quot_cb <= quot_cb + 4'd1; end
            if (rem_cr >= SIX) begin rem_cr <= rem_cr - SIX; quot_cr <= quot_cr + 4'd1; end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qp_derive_seq.sv
// Directed bench for qp_derive_seq: 8-bit and 10-bit instances share one stimulus set.
module tb_qp_derive_seq;
  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic signed [6:0] pred;
  logic signed [7:0] delta;
  logic signed [4:0] cbo, cro;
`ifdef QP_CHROMA_422_EN
  logic fmt;
`endif

  logic a_busy, a_done, b_busy, b_done;
  logic [6:0] a_y, a_cb, a_cr, b_y, b_cb, b_cr;
  logic [3:0] a_yd, a_cbd, a_crd, b_yd, b_cbd, b_crd;
  logic [2:0] a_ym, a_cbm, a_crm, b_ym, b_cbm, b_crm;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  qp_derive_seq #(.BIT_DEPTH(8), .QP_W(7)) u8 (
    .clk(clk), .rstn(rstn), .start_i(start), .qp_pred_i(pred), .delta_qp_i(delta),
    .cb_offset_i(cbo), .cr_offset_i(cro),
`ifdef QP_CHROMA_422_EN
    .chroma_fmt_i(fmt),
`endif
    .busy_o(a_busy), .done_o(a_done), .qp_y_o(a_y), .qp_cb_o(a_cb), .qp_cr_o(a_cr),
    .qp_y_div6_o(a_yd), .qp_cb_div6_o(a_cbd), .qp_cr_div6_o(a_crd),
    .qp_y_mod6_o(a_ym), .qp_cb_mod6_o(a_cbm), .qp_cr_mod6_o(a_crm));

  qp_derive_seq #(.BIT_DEPTH(10), .QP_W(7)) u10 (
    .clk(clk), .rstn(rstn), .start_i(start), .qp_pred_i(pred), .delta_qp_i(delta),
    .cb_offset_i(cbo), .cr_offset_i(cro),
`ifdef QP_CHROMA_422_EN
    .chroma_fmt_i(fmt),
`endif
    .busy_o(b_busy), .done_o(b_done), .qp_y_o(b_y), .qp_cb_o(b_cb), .qp_cr_o(b_cr),
    .qp_y_div6_o(b_yd), .qp_cb_div6_o(b_cbd), .qp_cr_div6_o(b_crd),
    .qp_y_mod6_o(b_ym), .qp_cb_mod6_o(b_cbm), .qp_cr_mod6_o(b_crm));

  typedef struct {
    int pred, delta, cb, cr;
    int y, qcb, qcr, n;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // idx: 0 y,1 cb,2 cr,3..5 div6,6..8 mod6,9 busy,10 done
  function automatic int get_out(input bit sel, input int idx);
    case (idx)
      0: return sel ? int'(b_y)   : int'(a_y);
      1: return sel ? int'(b_cb)  : int'(a_cb);
      2: return sel ? int'(b_cr)  : int'(a_cr);
      3: return sel ? int'(b_yd)  : int'(a_yd);
      4: return sel ? int'(b_cbd) : int'(a_cbd);
      5: return sel ? int'(b_crd) : int'(a_crd);
      6: return sel ? int'(b_ym)  : int'(a_ym);
      7: return sel ? int'(b_cbm) : int'(a_cbm);
      8: return sel ? int'(b_crm) : int'(a_crm);
      9: return sel ? int'(b_busy) : int'(a_busy);
      default: return sel ? int'(b_done) : int'(a_done);
    endcase
  endfunction

  task automatic check_outs(input bit sel, input string tag, input int y, input int cb, input int cr);
    chk({tag, ".qp_y"},  get_out(sel, 0), y);
    chk({tag, ".qp_cb"}, get_out(sel, 1), cb);
    chk({tag, ".qp_cr"}, get_out(sel, 2), cr);
    chk({tag, ".y_div6"},  get_out(sel, 3), y / 6);
    chk({tag, ".cb_div6"}, get_out(sel, 4), cb / 6);
    chk({tag, ".cr_div6"}, get_out(sel, 5), cr / 6);
    chk({tag, ".y_mod6"},  get_out(sel, 6), y % 6);
    chk({tag, ".cb_mod6"}, get_out(sel, 7), cb % 6);
    chk({tag, ".cr_mod6"}, get_out(sel, 8), cr % 6);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulse start for one cycle; returns at the negedge following the sampling edge.
  task automatic kick(input vec_t v);
    @(negedge clk);
    pred = 7'(v.pred); delta = 8'(v.delta); cbo = 5'(v.cb); cro = 5'(v.cr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts clocks from the start-sampling edge to done_o, checking busy meanwhile.
  task automatic wait_done(input bit sel, output int lat, output int busy_bad);
    lat = 0; busy_bad = 0;
    while (get_out(sel, 10) == 0 && lat < 40) begin
      if (get_out(sel, 9) != 1) busy_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input bit sel, input string tag, input vec_t v);
    int lat, bb;
    kick(v);
    wait_done(sel, lat, bb);
    chk({tag, ".latency"}, lat, v.n + 4);
    chk({tag, ".busy_run"}, bb, 0);
    chk({tag, ".busy_at_done"}, get_out(sel, 9), 1);
    check_outs(sel, tag, v.y, v.qcb, v.qcr);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, get_out(sel, 10), 0);
    chk({tag, ".busy_after"}, get_out(sel, 9), 0);
    check_outs(sel, {tag, ".hold"}, v.y, v.qcb, v.qcr);
    idle_cycles(14);
  endtask

  vec_t tbl[6];
  vec_t v;
  int lat, bb, dcount;

  initial begin
    rstn = 1'b0; start = 1'b0; pred = '0; delta = '0; cbo = '0; cro = '0;
`ifdef QP_CHROMA_422_EN
    fmt = 1'b0;
`endif
    //           pred delta  cb   cr   y   cb  cr  N
    tbl[0] = '{  30,    0,   0,   0,  30, 29, 29, 5};
    tbl[1] = '{  51,   25,   0,   0,  24, 24, 24, 4};
    tbl[2] = '{   0,  -26,   0,   0,  26, 26, 26, 4};
    tbl[3] = '{  51,    0,  12, -12,  51, 51, 35, 8};
    tbl[4] = '{  20,    5,   3,  -4,  25, 28, 21, 4};
    tbl[5] = '{  35,    0,   0,   8,  35, 33, 37, 6};

    idle_cycles(3);
    check_outs(1'b0, "reset8", 0, 0, 0);
    chk("reset8.busy", int'(a_busy), 0);
    chk("reset8.done", int'(a_done), 0);
    chk("reset10.qp_y", int'(b_y), 0);
    rstn = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 6; i++) run_vec(1'b0, $sformatf("vec%0d", i), tbl[i]);

    // 10-bit: QpY=-12 maps to Qp'=0 on every channel.
    v = '{-12, 0, 0, 0, 0, 0, 0, 0};
    run_vec(1'b1, "bd10_min", v);

    // start_i asserted during DIV and during DONE must be ignored.
    kick(tbl[0]);
    lat = 0; bb = 0;
    while (a_done == 1'b0 && lat < 40) begin
      if (lat == 5) begin pred = 7'sd0; delta = -8'sd26; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("ign.latency", lat, 9);
    check_outs(1'b0, "ign", 30, 29, 29);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign.busy_after_done", int'(a_busy), 0);
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      if (a_done || a_busy) dcount++;
      @(negedge clk);
    end
    chk("ign.no_restart", dcount, 0);
    check_outs(1'b0, "ign.hold", 30, 29, 29);

    // Reset mid-DIV: outputs clear, no done pulse afterwards.
    v = tbl[3];
    kick(v);
    idle_cycles(5);
    rstn = 1'b0;
    @(negedge clk);
    check_outs(1'b0, "rstdiv", 0, 0, 0);
    chk("rstdiv.busy", int'(a_busy), 0);
    chk("rstdiv.done", int'(a_done), 0);
    rstn = 1'b1;
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      if (a_done) dcount++;
      @(negedge clk);
    end
    chk("rstdiv.no_done", dcount, 0);

`ifdef QP_CHROMA_422_EN
    fmt = 1'b1;
    v = '{40, 0, 0, 0, 40, 40, 40, 6};
    run_vec(1'b0, "fmt422", v);
    fmt = 1'b0;
    v = '{40, 0, 0, 0, 40, 36, 36, 6};
    run_vec(1'b0, "fmt420", v);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
